hazard_scoreboard: RTL
======================

# hazard_scoreboard

Next-generation hazard unit for the pipelined MIPS core, replacing the purely combinational hazard logic. It keeps the E- and D-stage forwarding and the load-use and branch stalls, and adds a registered scoreboard for one outstanding multi-cycle multiply/divide operation with programmable latency. It also adds jump squashing instead of jump stalling, a saturating stall-cycle counter, and a sticky structural-error flag. It sits beside the datapath and drives the F/D stall enables, the D/E flush controls and the forwarding mux selects.

## Interface
Parameters:
- REG_W, 5: register-index width (2**REG_W architectural registers; register 0 is hardwired zero).
- MD_LAT, 4: cycles from multi-cycle issue (leaving E) to writeback on the W ports; legal range 2..15.
- CNT_W, 16: stall-counter width.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_n_i, in, 1: synchronous, active-low reset.
- branch_d_i, jump_d_i, md_d_i, rfwrite_d_i, in, 1 each: D-stage instruction is a branch, a jump, a multi-cycle op, or a register writer.
- memtorf_e_i, rfwrite_e_i, memtorf_m_i, rfwrite_m_i, rfwrite_w_i, in, 1 each: stage controls.
- md_issue_e_i, in, 1: multi-cycle op leaves E this cycle; its destination is writerf_e_i.
- rs_d_i, rt_d_i, writerf_d_i, rs_e_i, rt_e_i, writerf_e_i, writerf_m_i, writerf_w_i, in, REG_W each: register indices.
- stall_f_o, stall_d_o, flush_e_o, flush_d_o, out, 1 each: pipeline control.
- forwardad_o, forwardbd_o, out, 1 each: D-stage forward from M.
- forwardae_o, forwardbe_o, out, 2 each: 00 regfile, 01 from W, 10 from M.
- md_busy_o, out, 1: scoreboard holds a pending destination.
- md_err_o, out, 1: sticky; md_issue_e_i seen while busy.
- stall_cnt_o, out, CNT_W: saturating count of cycles with stall_d_o = 1.

## Operation
- forwardae_o/forwardbe_o: M beats W. Select 10 if the E source is nonzero, equals writerf_m_i and rfwrite_m_i = 1; else 01 on the same test against W; else 00.
- forwardad_o/forwardbd_o: the D source is nonzero, equals writerf_m_i and rfwrite_m_i = 1.
- lwstall: memtorf_e_i = 1 and rt_e_i != 0 and (rs_d_i == rt_e_i or rt_d_i == rt_e_i).
- branchstall: branch_d_i = 1 and either of:
  - rfwrite_e_i = 1, writerf_e_i != 0 and it matches rs_d_i or rt_d_i;
  - memtorf_m_i = 1, writerf_m_i != 0 and it matches rs_d_i or rt_d_i.
- Scoreboard state: md_dest (REG_W), md_cnt (4 bits). md_busy_o = (md_cnt != 0).
  - On md_issue_e_i with writerf_e_i != 0: load md_dest = writerf_e_i and md_cnt = MD_LAT.
  - Otherwise, if md_cnt != 0, decrement it. The md unit's writeback appears on the W ports in the cycle md_cnt == 1.
- mdstall: md_busy_o = 1 and any of:
  - RAW: rs_d_i or rt_d_i is nonzero and equals md_dest;
  - WAW: rfwrite_d_i = 1 and writerf_d_i == md_dest;
  - structural: md_d_i = 1 and md_cnt > 1.
- stall_d_o = stall_f_o = flush_e_o = lwstall | branchstall | mdstall.
- Jumps do not stall: flush_d_o = jump_d_i & ~stall_d_o, which squashes the wrongly fetched instruction.
- md_err_o: set when md_issue_e_i = 1 while md_cnt > 1; cleared only by reset.
- stall_cnt_o: increments each cycle stall_d_o = 1 and holds at all-ones.

## Timing
- All outputs are combinational from the current inputs and registered state; there are no registered outputs. The control outputs (stall_f_o, stall_d_o, flush_e_o, flush_d_o, forwarding selects) have zero latency.
- Reset values: md_cnt = 0, md_dest = 0, md_err_o = 0, stall_cnt_o = 0. With quiet inputs every output is 0 and md_busy_o = 0.
- Reset asserted mid-operation clears the scoreboard on that edge; a dependent D instruction is released in the next cycle.
- md_issue_e_i with writerf_e_i == 0 loads nothing.
- Issue in the same cycle as md_cnt == 1: the load wins, giving back-to-back issue with no error.
- D-dependent stall lasts MD_LAT cycles after issue, ending in the cycle after the writeback cycle (md_cnt == 0).
- Simultaneous lwstall and jump: stall_d_o = 1 and flush_d_o = 0.

## Test plan
- Reset: rst_n_i = 0 with random inputs, then quiet inputs -> all outputs 0, stall_cnt_o = 0.
- Forwarding: rs_e_i = 3, writerf_m_i = 3, writerf_w_i = 3, rfwrite_m_i = rfwrite_w_i = 1 -> forwardae_o = 10. Same with rs_e_i = 0 -> 00.
- Load-use: memtorf_e_i = 1, rt_e_i = 5, rs_d_i = 5 -> stall_f_o = stall_d_o = flush_e_o = 1. With rt_e_i = 0 -> no stall.
- Scoreboard (MD_LAT = 4): issue with writerf_e_i = 8, and rs_d_i = 8 held -> stall_d_o high for 4 cycles, then low; md_busy_o falls together with the stall; stall_cnt_o = 4.
- Structural and error: second md_d_i during busy stalls while md_cnt > 1. Forcing md_issue_e_i at md_cnt = 3 -> md_err_o = 1, held until reset.
- Jump and counter: jump_d_i = 1 with no hazard -> flush_d_o = 1 and stall_d_o = 0. Counter with CNT_W = 2 under a 6-cycle stall -> stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit: forwarding selects, load-use/branch stalls, multi-cycle op scoreboard, jump squash.
// Latency: all control outputs are combinational (zero cycles); scoreboard/counter/error state registered.
// Backpressure: stalls F/D and flushes E on any hazard; no handshake of its own.
module hazard_scoreboard #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             branch_d_i,
  input  logic             jump_d_i,
  input  logic             md_d_i,
  input  logic             rfwrite_d_i,
  input  logic             memtorf_e_i,
  input  logic             rfwrite_e_i,
  input  logic             memtorf_m_i,
  input  logic             rfwrite_m_i,
  input  logic             rfwrite_w_i,
  input  logic             md_issue_e_i,
  input  logic [REG_W-1:0] rs_d_i,
  input  logic [REG_W-1:0] rt_d_i,
  input  logic [REG_W-1:0] writerf_d_i,
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rt_e_i,
  input  logic [REG_W-1:0] writerf_e_i,
  input  logic [REG_W-1:0] writerf_m_i,
  input  logic [REG_W-1:0] writerf_w_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             flush_e_o,
  output logic             flush_d_o,
  output logic             forwardad_o,
  output logic             forwardbd_o,
  output logic [1:0]       forwardae_o,
  output logic [1:0]       forwardbe_o,
  output logic             md_busy_o,
  output logic             md_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] LP_MD_LAT = 4'(MD_LAT);

  logic [REG_W-1:0] r_md_dest;
  logic [3:0]       r_md_cnt;
  logic             r_md_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lwstall;
  logic w_branchstall;
  logic w_mdstall;
  logic w_md_busy;
  logic w_stall;
  logic w_md_load;

  // E-stage source select: the younger M result takes priority over W.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wr_m, input logic we_m,
                                         input logic [REG_W-1:0] wr_w, input logic we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0 && src == wr_m && we_m)      sel = 2'b10;
    else if (src != '0 && src == wr_w && we_w) sel = 2'b01;
    return sel;
  endfunction

  // Forwarding mux selects for E and D stages.
  always_comb begin
    forwardae_o = fwd_sel(rs_e_i, writerf_m_i, rfwrite_m_i, writerf_w_i, rfwrite_w_i);
    forwardbe_o = fwd_sel(rt_e_i, writerf_m_i, rfwrite_m_i, writerf_w_i, rfwrite_w_i);
    forwardad_o = (rs_d_i != '0) && (rs_d_i == writerf_m_i) && rfwrite_m_i;
    forwardbd_o = (rt_d_i != '0) && (rt_d_i == writerf_m_i) && rfwrite_m_i;
  end

  // Hazard detection; a busy scoreboard blocks readers, writers of the same
  // register and a new multi-cycle op unless it would issue on the writeback cycle.
  always_comb begin
    w_md_busy     = (r_md_cnt != 4'd0);
    w_lwstall     = memtorf_e_i && (rt_e_i != '0) &&
                    ((rs_d_i == rt_e_i) || (rt_d_i == rt_e_i));
    w_branchstall = branch_d_i &&
                    ((rfwrite_e_i && (writerf_e_i != '0) &&
                      ((writerf_e_i == rs_d_i) || (writerf_e_i == rt_d_i))) ||
                     (memtorf_m_i && (writerf_m_i != '0) &&
                      ((writerf_m_i == rs_d_i) || (writerf_m_i == rt_d_i))));
    w_mdstall     = w_md_busy &&
                    (((rs_d_i != '0) && (rs_d_i == r_md_dest)) ||
                     ((rt_d_i != '0) && (rt_d_i == r_md_dest)) ||
                     (rfwrite_d_i && (writerf_d_i == r_md_dest)) ||
                     (md_d_i && (r_md_cnt > 4'd1)));
    w_stall       = w_lwstall || w_branchstall || w_mdstall;
    w_md_load     = md_issue_e_i && (writerf_e_i != '0);
  end

  // Pipeline control; a stalled jump must not squash the instruction behind it.
  always_comb begin
    stall_f_o   = w_stall;
    stall_d_o   = w_stall;
    flush_e_o   = w_stall;
    flush_d_o   = jump_d_i && !w_stall;
    md_busy_o   = w_md_busy;
    md_err_o    = r_md_err;
    stall_cnt_o = r_stall_cnt;
  end

  // Scoreboard: a new issue overrides the countdown, so issuing on the writeback cycle is legal.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_md_dest <= '0;
      r_md_cnt  <= 4'd0;
    end else if (w_md_load) begin
      r_md_dest <= writerf_e_i;
      r_md_cnt  <= LP_MD_LAT;
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt  <= r_md_cnt - 4'd1;
    end
  end

  // Sticky error: an issue while the previous op still has more than its writeback cycle left.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                            r_md_err <= 1'b0;
    else if (md_issue_e_i && r_md_cnt > 4'd1) r_md_err <= 1'b1;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                          r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule
